// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: computes a - b - bin one bit per clock, LSB first,
// with operands and result exchanged on valid/ready handshakes.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_am;
    logic             r_bm;
    logic             r_bout;
    logic             r_ovf;

    logic w_x;
    logic w_y;
    logic w_d;
    logic w_br_next;
    logic w_accept;
    logic w_last;
    logic w_release;
    logic w_ovf_now;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    assign w_x       = r_sa[0];
    assign w_y       = r_sb[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_release = (r_state == DONE) && out_ready;
    assign w_ovf_now = (r_am != r_bm) && (r_res[WIDTH-1] != r_am);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_am   <= 1'b0;
            r_bm   <= 1'b0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sa  <= a;
                r_sb  <= b;
                r_br  <= bin;
                r_cnt <= '0;
                r_am  <= a[WIDTH-1];
                r_bm  <= b[WIDTH-1];
            end else if (r_state == SHIFT) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_res <= {w_d, r_res[WIDTH-1:1]};
                r_br  <= w_br_next;
                if (!w_last) r_cnt <= r_cnt + 1'b1;
            end
            // The delivered result is parked here so outputs hold it while the next op shifts.
            if (w_release) begin
                r_diff <= r_res;
                r_bout <= r_br;
                r_ovf  <= w_ovf_now;
            end
        end
    end

    always_comb begin
        diff = r_diff;
        bout = r_bout;
        ovf  = r_ovf;
        if (r_state == DONE) begin
            diff = r_res;
            bout = r_br;
            ovf  = w_ovf_now;
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed vectors, handshake corners,
// mid-operation reset and a randomized sweep against an arithmetic reference.
module tb_serial_sub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer subtraction; borrow is the sign of the true result.
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        int r;
        logic [7:0] d;
        logic bo, ov;
        r  = int'(x) - int'(y) - int'(c);
        bo = (r < 0);
        d  = r[7:0];
        ov = (x[7] != y[7]) && (d[7] != x[7]);
        return {d, bo, ov};
    endfunction

    // Drives one op; result sampled after 'hold' extra cycles of out_ready=0.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                          input int hold, output logic [9:0] got, output int lat);
        int w;
        @(negedge clk);
        a = ai; b = bi; bin = ci; in_valid = 1'b1; out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        repeat (hold) @(negedge clk);
        got = {diff, bout, ovf};
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({in_ready, out_valid, diff, bout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_state got=%b want=%b", {in_ready, out_valid, diff, bout, ovf},
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] va [6] = '{8'd200, 8'd5,  8'h80, 8'h7F, 8'h00, 8'hFF};
        logic [7:0] vb [6] = '{8'd55,  8'd10, 8'h01, 8'hFF, 8'h00, 8'hFF};
        logic       vc [6] = '{1'b0,   1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        logic [9:0] ve [6] = '{{8'd145, 2'b00}, {8'hFB, 2'b10}, {8'h7F, 2'b01},
                               {8'h80, 2'b11}, {8'hFF, 2'b10}, {8'hFF, 2'b10}};
        logic [9:0] got;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vc[i], 0, got, lat);
            n_total++;
            if (got !== ve[i])
                $display("FAIL directed_%0d {diff,bout,ovf} got=%h/%b/%b want=%h/%b/%b", i,
                         got[9:2], got[1], got[0], ve[i][9:2], ve[i][1], ve[i][0]);
            else n_pass++;
            n_total++;
            if (lat !== W) $display("FAIL directed_latency_%0d got=%0d want=%0d", i, lat, W);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] prev, exp;
        int w;
        prev = {diff, bout, ovf};
        exp  = ref_sub(8'h3C, 8'h5A, 1'b1);
        @(negedge clk);
        a = 8'h3C; b = 8'h5A; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // In SHIFT now: new operands must be ignored and outputs must hold the old result.
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); in_valid = 1'b1;
            n_total++;
            if ({in_ready, diff, bout, ovf} !== {1'b0, prev})
                $display("FAIL shift_hold_%0d got=%b want=%b", i, {in_ready, diff, bout, ovf}, {1'b0, prev});
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); in_valid = 1'($urandom);
            n_total++;
            if ({out_valid, in_ready, diff, bout, ovf} !== {2'b10, exp})
                $display("FAIL stall_%0d got=%b want=%b", i, {out_valid, in_ready, diff, bout, ovf}, {2'b10, exp});
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if ({out_valid, in_ready, diff, bout, ovf} !== {2'b01, exp})
            $display("FAIL release_no_same_cycle_accept got=%b want=%b",
                     {out_valid, in_ready, diff, bout, ovf}, {2'b01, exp});
        else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({out_valid, in_ready, diff, bout, ovf} !== {2'b01, exp})
            $display("FAIL idle_out_ready got=%b want=%b", {out_valid, in_ready, diff, bout, ovf}, {2'b01, exp});
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [9:0] got;
        int lat, seen;
        @(negedge clk);
        a = 8'hAA; b = 8'h11; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if ({in_ready, out_valid, diff, bout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
            $display("FAIL mid_reset_state got=%b want=%b", {in_ready, out_valid, diff, bout, ovf},
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        else n_pass++;
        seen = 0;
        repeat (12) begin @(negedge clk); if (out_valid) seen++; end
        n_total++;
        if (seen !== 0) $display("FAIL mid_reset_discard got=%0d want=0", seen);
        else n_pass++;
        run_op(8'd9, 8'd3, 1'b0, 0, got, lat);
        n_total++;
        if (got !== {8'd6, 2'b00}) $display("FAIL post_reset_op got=%b want=%b", got, {8'd6, 2'b00});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int w, results;
        logic [9:0] exp;
        exp = ref_sub(8'd77, 8'd140, 1'b1);
        results = 0;
        @(negedge clk);
        a = 8'd77; b = 8'd140; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (40) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                results++;
                n_total++;
                if ({diff, bout, ovf} !== exp)
                    $display("FAIL b2b_result got=%b want=%b", {diff, bout, ovf}, exp);
                else n_pass++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        w = 0;
        while (!in_ready && w < 40) begin @(negedge clk); w++; end
        n_total++;
        if (acc.size() < 3 || results < 3)
            $display("FAIL b2b_count got=%0d accepts %0d results want>=3", acc.size(), results);
        else n_pass++;
        for (int i = 1; i < acc.size(); i++) begin
            n_total++;
            if (acc[i] - acc[i-1] !== W + 2)
                $display("FAIL b2b_period got=%0d want=%0d", acc[i] - acc[i-1], W + 2);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        logic rc;
        logic [9:0] got, exp;
        int lat, hold;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            exp = ref_sub(ra, rb, rc);
            run_op(ra, rb, rc, hold, got, lat);
            n_total++;
            if (got !== exp)
                $display("FAIL random_%0d a=%h b=%h bin=%b got=%b want=%b", i, ra, rb, rc, got, exp);
            else n_pass++;
            n_total++;
            if (lat !== W) $display("FAIL random_latency_%0d got=%0d want=%0d", i, lat, W);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d checks want=completion", n_total);
        $fatal(1, "timeout");
    end

endmodule
